modport_blk: RTL and testbench

MODPORT_BLK -- requirements
Module: modport_blk

---
 rtl/modport_blk.sv | 217 +++++++++++++++++++++
 tb/tb_modport_blk.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/modport_blk.sv
// modport_blk: single-source packet router feeding three byte FIFOs.
//
// A packet is a header byte (addr = [1:0], LEN = [7:2]), LEN payload bytes
// and one parity byte. Packets for addresses 0..2 are stored in full
// (header, payload, parity) in the matching FIFO. Packets for address 3 are
// consumed and discarded. A parity mismatch raises err for one cycle.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous active-high reset
//   pkt_valid, data_in source byte strobe and byte
//   read_en_0/1/2      destination pop requests
//   dout_0/1/2         registered popped bytes
//   vld_out_0/1/2      destination FIFO non-empty
//   busy               source must hold its byte while high
//   err                one-cycle parity-mismatch pulse
//
// Parameter FIFO_DEPTH: entries per destination FIFO.
// Optional feature macro MODPORT_SOFT_RESET_EN: a destination FIFO that
// stays non-empty and unread for 30 cycles is flushed.
module modport_blk #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       read_en_0,
  input  logic       read_en_1,
  input  logic       read_en_2,
  output logic [7:0] dout_0,
  output logic [7:0] dout_1,
  output logic [7:0] dout_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       busy,
  output logic       err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [7:0]      parity_q, parity_d;
  logic            err_q, err_d;

  logic [AW-1:0]   wr_ptr_q [3];
  logic [AW-1:0]   wr_ptr_d [3];
  logic [AW-1:0]   rd_ptr_q [3];
  logic [AW-1:0]   rd_ptr_d [3];
  logic [CW-1:0]   count_q  [3];
  logic [CW-1:0]   count_d  [3];
  logic [7:0]      dout_q   [3];
  logic [7:0]      dout_d   [3];
  logic [7:0]      mem_q    [3][FIFO_DEPTH];

`ifdef MODPORT_SOFT_RESET_EN
  logic [4:0]      to_cnt_q [3];
  logic [4:0]      to_cnt_d [3];
`endif

  logic [2:0]      read_en;
  logic [2:0]      push;
  logic [2:0]      pop;
  // Bit 3 stands for the drop address and is never full.
  logic [3:0]      full_v;
  logic            accept;

  assign read_en = {read_en_2, read_en_1, read_en_0};

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    if (p == AW'(FIFO_DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  always_comb begin
    full_v = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      full_v[i] = (count_q[i] == CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      IDLE:            busy = full_v[data_in[1:0]];
      PAYLOAD, PARITY: busy = full_v[addr_q];
      default:         busy = 1'b0;
    endcase
  end

  assign accept = pkt_valid && !busy;

  // Packet framing FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    err_d    = 1'b0;
    push     = '0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          addr_d = data_in[1:0];
          len_d  = data_in[7:2];
          cnt_d  = '0;
          if (data_in[1:0] == 2'd3) begin
            state_d = DROP;
          end else begin
            push     = 3'b001 << data_in[1:0];
            parity_d = data_in;
            state_d  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          push     = 3'b001 << addr_q;
          parity_d = parity_q ^ data_in;
          if (cnt_q == len_q - 6'd1) state_d = PARITY;
          else                       cnt_d   = cnt_q + 6'd1;
        end
        PARITY: begin
          push    = 3'b001 << addr_q;
          err_d   = (data_in != parity_q);
          state_d = IDLE;
        end
        default: begin
          // Header already consumed; LEN payload bytes plus parity remain.
          if (cnt_q == len_q) state_d = IDLE;
          else                cnt_d   = cnt_q + 6'd1;
        end
      endcase
    end
  end

  // FIFO pointer/count/output-register next state.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      pop[i]      = read_en[i] && (count_q[i] != '0);
      wr_ptr_d[i] = push[i] ? inc_ptr(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? inc_ptr(rd_ptr_q[i]) : rd_ptr_q[i];
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      dout_d[i]   = pop[i] ? mem_q[i][rd_ptr_q[i]] : dout_q[i];
`ifdef MODPORT_SOFT_RESET_EN
      to_cnt_d[i] = '0;
      if ((count_q[i] != '0) && !read_en[i]) begin
        if (to_cnt_q[i] == 5'd29) begin
          // Flush: discard everything including a same-cycle push.
          rd_ptr_d[i] = wr_ptr_d[i];
          count_d[i]  = '0;
        end else begin
          to_cnt_d[i] = to_cnt_q[i] + 5'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      parity_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        dout_q[i]   <= '0;
`ifdef MODPORT_SOFT_RESET_EN
        to_cnt_q[i] <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
        dout_q[i]   <= dout_d[i];
`ifdef MODPORT_SOFT_RESET_EN
        to_cnt_q[i] <= to_cnt_d[i];
`endif
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

  assign dout_0    = dout_q[0];
  assign dout_1    = dout_q[1];
  assign dout_2    = dout_q[2];
  assign vld_out_0 = (count_q[0] != '0);
  assign vld_out_1 = (count_q[1] != '0);
  assign vld_out_2 = (count_q[2] != '0);
  assign err       = err_q;

endmodule

// File: tb/tb_modport_blk.sv
module tb_modport_blk;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       read_en_0, read_en_1, read_en_2;
  logic [7:0] dout_0, dout_1, dout_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  modport_blk #(.FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_en_0(read_en_0), .read_en_1(read_en_1), .read_en_2(read_en_2),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic       pv;
    logic [7:0] din;
    logic [2:0] re;
    logic [2:0] vld;
    logic [7:0] d1;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    pkt_valid = 1'b1;
    data_in   = b;
    tick();
    pkt_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [$];
    logic [7:0] got_b [$];
    logic [7:0] p36 [22];
    logic [7:0] drainb [5];
    int idx, cyc, busy_idx;
    logic phase2, acc, pp, err_seen;

    // Packet A: addr 1 read continuously; drop packet; packet B with bad parity.
    vecs.push_back('{1'b1, 8'h0D, 3'b010, 3'b010, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 8'h11, 3'b010, 3'b010, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h22, 3'b010, 3'b010, 8'h11, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 3'b010, 3'b010, 8'h22, 1'b0});
    vecs.push_back('{1'b1, 8'h0D, 3'b010, 3'b010, 8'h33, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 3'b010, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 3'b010, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h0F, 3'b000, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'hAA, 3'b000, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'hBB, 3'b000, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'hCC, 3'b000, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'hDD, 3'b000, 3'b000, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h0D, 3'b000, 3'b010, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h11, 3'b000, 3'b010, 8'h0D, 1'b0});
    vecs.push_back('{1'b0, 8'hFF, 3'b000, 3'b010, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h22, 3'b000, 3'b010, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 3'b000, 3'b010, 8'h0D, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 3'b000, 3'b010, 8'h0D, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 3'b000, 3'b010, 8'h0D, 1'b0});

    drainb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    p36[0] = 8'h50;
    for (int k = 1; k <= 20; k++) p36[k] = 8'(k);
    p36[21] = 8'h44;

    reset = 1'b1; pkt_valid = 1'b0; data_in = '0;
    read_en_0 = 1'b0; read_en_1 = 1'b0; read_en_2 = 1'b0;
    tick(); tick();
    chk("rst_vld", {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    chk("rst_dout", {8'd0, dout_2, dout_1, dout_0}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      pkt_valid = vecs[v].pv;
      data_in   = vecs[v].din;
      {read_en_2, read_en_1, read_en_0} = vecs[v].re;
      tick();
      chk($sformatf("vec%0d_vld", v), {29'd0, vld_out_2, vld_out_1, vld_out_0}, {29'd0, vecs[v].vld});
      chk($sformatf("vec%0d_dout1", v), {24'd0, dout_1}, {24'd0, vecs[v].d1});
      chk($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].er});
      chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    end
    pkt_valid = 1'b0;

    // Drain packet B: data kept despite the parity error.
    read_en_1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("drainB_%0d", k), {24'd0, dout_1}, {24'd0, drainb[k]});
    end
    read_en_1 = 1'b0;
    chk("drainB_vld1", {31'd0, vld_out_1}, 32'd0);

    // Long packet to addr 0: back-pressure after 16 bytes, then drain with wrap.
    idx = 0; cyc = 0; busy_idx = -1; phase2 = 1'b0; err_seen = 1'b0;
    got_b.delete();
    while (got_b.size() < 22 && cyc < 300) begin
      pkt_valid = (idx < 22);
      data_in   = (idx < 22) ? p36[idx] : 8'h00;
      read_en_0 = phase2;
      #1;
      acc = pkt_valid && !busy;
      pp  = read_en_0 && vld_out_0;
      if (!phase2 && busy) begin
        busy_idx = idx;
        phase2   = 1'b1;
      end
      @(posedge clock);
      #1;
      if (acc) idx++;
      if (pp) got_b.push_back(dout_0);
      if (err) err_seen = 1'b1;
      cyc++;
    end
    pkt_valid = 1'b0; read_en_0 = 1'b0;
    chk("long_busy_at", busy_idx, 32'd16);
    chk("long_count", got_b.size(), 32'd22);
    for (int k = 0; k < 22; k++) begin
      if (k < got_b.size()) chk($sformatf("long_b%0d", k), {24'd0, got_b[k]}, {24'd0, p36[k]});
      else chk($sformatf("long_b%0d", k), 32'hFFFF_FFFF, {24'd0, p36[k]});
    end
    chk("long_err", {31'd0, err_seen}, 32'd0);
    chk("long_vld0", {31'd0, vld_out_0}, 32'd0);

    // Addr 2 packet left unread for 40 cycles.
    send_byte(8'h06); send_byte(8'h5A); send_byte(8'h5C);
    for (int k = 0; k < 40; k++) tick();
`ifdef MODPORT_SOFT_RESET_EN
    chk("idle_vld2", {31'd0, vld_out_2}, 32'd0);
`else
    chk("idle_vld2", {31'd0, vld_out_2}, 32'd1);
    exp_b = '{8'h06, 8'h5A, 8'h5C};
    read_en_2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("addr2_b%0d", k), {24'd0, dout_2}, {24'd0, exp_b[k]});
    end
    read_en_2 = 1'b0;
`endif
    chk("addr2_vld_end", {31'd0, vld_out_2}, 32'd0);

    // Reset mid-payload, then a clean packet.
    send_byte(8'h0D); send_byte(8'h11);
    reset = 1'b1;
    tick();
    chk("mrst_vld", {29'd0, vld_out_2, vld_out_1, vld_out_0}, 32'd0);
    chk("mrst_dout", {8'd0, dout_2, dout_1, dout_0}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    send_byte(8'h0D); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h0D);
    chk("mrst_err_after", {31'd0, err}, 32'd0);
    exp_b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    read_en_1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("mrst_b%0d", k), {24'd0, dout_1}, {24'd0, exp_b[k]});
    end
    read_en_1 = 1'b0;
    chk("mrst_vld1_end", {31'd0, vld_out_1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
